filter_chain_seq: RTL and testbench

FILTER_CHAIN_SEQ -- requirements
Module: filter_chain_seq

---
 rtl/filter_chain_seq.sv | 138 +++++++++++++
 tb/tb_filter_chain_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_chain_seq.sv
// Sequencer that walks one codec sample through NSTAGE filter stages on a shared engine.
// Enabled stages are issued to the engine in order; bypassed or timed-out stages leave the sample untouched.
module filter_chain_seq #(
    parameter int W       = 24,
    parameter int NSTAGE  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_trig,
    input  logic [W-1:0]      data_in,
    input  logic [NSTAGE-1:0] stage_en,
    input  logic              clr_err,
    output logic              eng_start,
    output logic [1:0]        eng_sel,
    output logic [W-1:0]      eng_din,
    input  logic              eng_done,
    input  logic [W-1:0]      eng_dout,
    output logic [W-1:0]      data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int         TW   = $clog2(TIMEOUT + 1);
    localparam logic [1:0] LAST = 2'(NSTAGE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [1:0]     r_idx;
    logic [W-1:0]   r_acc;
    logic [TW-1:0]  r_tcnt;
    logic [W-1:0]   r_data_out;
    logic           r_out_valid;
    logic           r_busy;
    logic           r_overrun;
    logic           r_timeout_err;

    logic           w_en_cur;
    logic           w_tmo;
    logic           w_advance;
    logic           w_last;
    logic [W-1:0]   w_next_acc;

    // The issue cycle counts toward the budget, so the stage gives up on its (TIMEOUT-1)th wait cycle.
    assign w_en_cur   = stage_en[r_idx];
    assign w_tmo      = (r_state == S_WAIT) && !eng_done && (r_tcnt == TW'(TIMEOUT - 2));
    assign w_advance  = ((r_state == S_ISSUE) && !w_en_cur) ||
                        ((r_state == S_WAIT) && (eng_done || w_tmo));
    assign w_last     = (r_idx == LAST);
    assign w_next_acc = ((r_state == S_WAIT) && eng_done) ? eng_dout : r_acc;

    // Start is decoded from the state register so the engine samples it on the edge that leaves ISSUE.
    assign eng_start   = (r_state == S_ISSUE) && w_en_cur;
    assign eng_sel     = eng_start ? r_idx : 2'd0;
    assign eng_din     = eng_start ? r_acc : '0;

    assign data_out    = r_data_out;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= 2'd0;
            r_acc         <= '0;
            r_tcnt        <= '0;
            r_data_out    <= '0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (sample_trig) begin
                        r_acc   <= data_in;
                        r_idx   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_en_cur) begin
                        r_tcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!eng_done && !w_tmo) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Shared step taken by a bypassed, completed or timed-out stage.
            if (w_advance) begin
                r_acc <= w_next_acc;
                if (w_last) begin
                    r_data_out  <= w_next_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end else begin
                    r_idx   <= r_idx + 2'd1;
                    r_state <= S_ISSUE;
                end
            end

            if (clr_err) begin
                r_overrun     <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (sample_trig && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_filter_chain_seq.sv
// Scoreboard bench for filter_chain_seq: an engine model answers starts after chosen delays,
// a reference model predicts result, latency and error flags, and a monitor checks each out_valid.
module tb_filter_chain_seq;

    localparam int W       = 24;
    localparam int NSTAGE  = 3;
    localparam int TIMEOUT = 255;

    logic              clk         = 1'b0;
    logic              reset_n     = 1'b0;
    logic              sample_trig = 1'b0;
    logic [W-1:0]      data_in     = '0;
    logic [NSTAGE-1:0] stage_en    = '0;
    logic              clr_err     = 1'b0;
    logic              eng_done    = 1'b0;
    logic [W-1:0]      eng_dout    = '0;
    logic              eng_start;
    logic [1:0]        eng_sel;
    logic [W-1:0]      eng_din;
    logic [W-1:0]      data_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        bit           tmo;
        bit           ovr;
    } expT;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] din;
    } startT;

    expT   sbq[$];
    startT startq[$];
    int    delayq[$];

    filter_chain_seq #(.W(W), .NSTAGE(NSTAGE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_trig (sample_trig),
        .data_in     (data_in),
        .stage_en    (stage_en),
        .clr_err     (clr_err),
        .eng_start   (eng_start),
        .eng_sel     (eng_sel),
        .eng_din     (eng_din),
        .eng_done    (eng_done),
        .eng_dout    (eng_dout),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: event not expected or not seen (cycle %0d)", name, cyc);
    endtask

    // Engine model: result is din+1, delivered a chosen number of cycles after the start (0 = never).
    initial begin
        int           countdown;
        int           d;
        logic [W-1:0] result;
        startT        s;
        countdown = 0;
        result    = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            eng_dout = W'($urandom);
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    eng_done = 1'b1;
                    eng_dout = result;
                end
            end
            if (eng_start) begin
                if (startq.size() == 0) begin
                    failNow("unexpected_eng_start");
                end else begin
                    s = startq.pop_front();
                    checkOutput("eng_sel", eng_sel, s.sel);
                    checkOutput("eng_din", eng_din, s.din);
                end
                d         = (delayq.size() > 0) ? delayq.pop_front() : 0;
                result    = eng_din + 1'b1;
                countdown = d;
            end
        end
    end

    // Monitor: every out_valid must match the oldest prediction.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    failNow("unexpected_out_valid");
                end else begin
                    e = sbq.pop_front();
                    checkOutput("data_out", data_out, e.data);
                    checkOutput("out_valid_cycle", cyc, e.cyc);
                    checkOutput("timeout_err_at_out", timeout_err, e.tmo);
                    checkOutput("overrun_at_out", overrun, e.ovr);
                end
            end
        end
    end

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) failNow("wait_idle_timeout");
    endtask

    // ovrMode: 0 none, 1 second trigger 3 cycles later, 2 second trigger landing in DONE.
    task automatic applyStimulus(input logic [W-1:0] data, input logic [NSTAGE-1:0] en,
                                 input int d0, input int d1, input int d2, input int ovrMode);
        int           dl[NSTAGE];
        logic [W-1:0] acc;
        int           lat;
        bit           tmo;
        int           ovrOff;
        startT        s;
        expT          e;
        dl[0] = d0;
        dl[1] = d1;
        dl[2] = d2;

        waitIdle();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checkOutput("overrun_cleared", overrun, 0);
        checkOutput("timeout_err_cleared", timeout_err, 0);

        stage_en = en;
        acc = data;
        lat = 1;
        tmo = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (!en[i]) begin
                lat += 1;
            end else begin
                s.sel = 2'(i);
                s.din = acc;
                startq.push_back(s);
                delayq.push_back(dl[i]);
                if (dl[i] >= 1 && dl[i] <= TIMEOUT - 1) begin
                    acc = acc + 1'b1;
                    lat += 1 + dl[i];
                end else begin
                    tmo = 1'b1;
                    lat += TIMEOUT;
                end
            end
        end
        ovrOff = (ovrMode == 1) ? 3 : (ovrMode == 2) ? lat : 0;
        e.data = acc;
        e.cyc  = cyc + lat;
        e.tmo  = tmo;
        e.ovr  = (ovrOff != 0) && (ovrOff < lat);
        sbq.push_back(e);

        sample_trig = 1'b1;
        data_in     = data;
        @(negedge clk);
        sample_trig = 1'b0;
        data_in     = W'($urandom);
        if (ovrOff != 0) begin
            repeat (ovrOff - 1) @(negedge clk);
            sample_trig = 1'b1;
            data_in     = W'($urandom);
            @(negedge clk);
            sample_trig = 1'b0;
        end

        waitIdle();
        checkOutput("overrun_after", overrun, (ovrOff != 0) ? 1 : 0);
        checkOutput("timeout_err_after", timeout_err, tmo ? 1 : 0);
    endtask

    function automatic int pickDelay();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 0;
        if (r == 1) return TIMEOUT - 1;
        if (r == 2) return TIMEOUT;
        return int'($urandom_range(1, 6));
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data_out"}, data_out, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_eng_start"}, eng_start, 0);
        checkOutput({tag, "_eng_sel"}, eng_sel, 0);
        checkOutput({tag, "_eng_din"}, eng_din, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
        checkOutput({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        startT s;
        int    mode;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;

        applyStimulus(24'h000010, 3'b111, 2, 2, 2, 0);
        applyStimulus(24'h800000, 3'b000, 1, 1, 1, 0);
        applyStimulus(24'h5A5A5A, 3'b010, 0, 0, 0, 0);
        applyStimulus(24'h123456, 3'b101, 1, 1, 1, 1);
        applyStimulus(24'hFFFFFF, 3'b001, 3, 1, 1, 2);

        for (int n = 0; n < 30; n++) begin
            mode = int'($urandom_range(0, 3));
            applyStimulus(W'($urandom), NSTAGE'($urandom_range(0, 7)),
                          pickDelay(), pickDelay(), pickDelay(), (mode < 2) ? mode + 1 : 0);
        end

        // Reset while waiting on the engine; its late answer must be ignored.
        waitIdle();
        stage_en = 3'b001;
        s.sel = 2'd0;
        s.din = 24'h0BEEF0;
        startq.push_back(s);
        delayq.push_back(10);
        sample_trig = 1'b1;
        data_in     = 24'h0BEEF0;
        @(negedge clk);
        sample_trig = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkAllZero("wait_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checkOutput("post_reset_out_valid", out_valid, 0);
            checkOutput("post_reset_busy", busy, 0);
        end

        checkOutput("scoreboard_drained", sbq.size(), 0);
        checkOutput("starts_drained", startq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
